mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
- Game-side controller that decides which of the 12 holes show a mole, and for how long.
- Resolves hammer hits against the active moles.
- Maintains lives and score, and raises win/lose.
- Its mole_up/live/is_win/is_lose outputs drive the display manager directly; tick is a slow game-rate enable pulse from the clock divider.

Parameters:
- NUM_MOLES, 12, number of holes (fixed at 12 by display layout).
- UP_TICKS, 48, ticks a mole stays up before counting as a miss (1..63).
- SPAWN_TICKS, 16, ticks between spawn attempts (1..255).
- MAX_ACTIVE, 3, maximum simultaneous moles up.
- LIVES, 3, lives loaded at game start (1..7).
- WIN_SCORE, 20, score that ends the game as a win (1..255).
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  single-cycle game-rate enable
- is_start  in  1  game enabled (level)
- is_pause  in  1  freeze game (level)
- hit_valid  in  1  single-cycle hammer strike
- hit_index  in  4  hole struck, 0..11; 12..15 means no hole
- mole_up  out  12  bit i = mole i up
- live  out  3  remaining lives
- score  out  8  moles hit this game
- is_win  out  1  game won (level)
- is_lose  out  1  game lost (level)

Behaviour:
- Single clock domain; reset is synchronous and active-high (sampled on posedge clk).
- All outputs are registered. Reset values: mole_up=0, live=LIVES, score=0, is_win=0, is_lose=0, state=IDLE, LFSR=LFSR_SEED, all timers=0.
- The LFSR (x^16+x^14+x^13+x^11) steps every clk cycle in every state, including IDLE.
- States: IDLE, RUN, PAUSED, WIN, LOSE.
  - Any state with is_start=0 -> IDLE next cycle. IDLE clears mole_up, score and timers, and sets live=LIVES.
  - IDLE & is_start -> RUN. Spawn counter loads SPAWN_TICKS.
  - RUN & is_pause -> PAUSED. PAUSED & !is_pause -> RUN.
  - PAUSED freezes timers, spawn counter, mole_up, score and live. tick and hit_valid are ignored in PAUSED.
  - RUN -> WIN when next score == WIN_SCORE. Otherwise RUN -> LOSE when next live == 0. If both occur in the same cycle, WIN has priority.
  - WIN/LOSE: mole_up cleared on entry; is_win or is_lose held high; stays there until is_start falls. live and score hold their final values.
- Per-mole 6-bit up timer:
  - Loaded with UP_TICKS when the mole spawns.
  - Decrements on tick while RUN and the mole is up.
  - On a tick where the timer == 1, the mole clears (timeout) and costs 1 life.
- Spawn:
  - On tick in RUN, the spawn counter decrements. At 0 it makes an attempt with idx = lfsr[3:0].
  - The attempt succeeds if idx < 12, mole_up[idx]=0, and popcount(mole_up) < MAX_ACTIVE. On success the bit is set and the counter reloads SPAWN_TICKS.
  - On failure the counter stays 0 and the attempt retries on the next tick.
- Hit:
  - hit_valid in RUN with hit_index < 12 and mole_up[hit_index]=1 clears that bit and increments score (saturating at 255).
  - A hit on an empty hole or an index >= 12 has no effect and no penalty.
  - The cleared bit is visible on the cycle after hit_valid (1-cycle latency).
- Simultaneous events in one cycle:
  - Hit and timeout on the same mole: the hit wins (score++, no life lost).
  - Hit and spawn on the same hole: the hit is evaluated against the pre-cycle mole_up; the spawn sees the post-hit vector.
  - Several timeouts: live decreases by the count, saturating at 0.
- is_pause is ignored in IDLE, WIN and LOSE.

Decomposition:
- Shared package (mole_pkg):
  - state encoding constants (IDLE/RUN/PAUSED/WIN/LOSE);
  - NUM_MOLES;
  - hole index width (4);
  - timer width (6).
- Sub-module mole_lfsr: 16-bit Galois LFSR with seed parameter and synchronous reset, free-running.
- Timers, popcount and FSM live in the top.

Test Plan:
- Reset, then is_start=1 with no hits (LIVES=3, UP_TICKS=4, SPAWN_TICKS=2, MAX_ACTIVE=1) -> first mole appears on the 2nd tick; each mole times out after 4 ticks; live goes 3->2->1->0; is_lose=1 and mole_up=0 after the 3rd timeout.
- Mole k up, hit_valid with hit_index=k -> mole_up[k]=0 on the next cycle and score +1. Same strike on an empty hole and on index 13 -> no change to score or live.
- Hit on the same cycle as that mole's final timeout tick -> score +1, live unchanged.
- WIN_SCORE=2 with two successive hits -> is_win=1 and mole_up=0. Deassert is_start -> IDLE with score=0, live=LIVES and is_win=0.
- is_pause=1 for 100 ticks mid-game -> mole_up, timers, score and live all frozen. Release -> remaining up time resumes exactly where it stopped.
- MAX_ACTIVE=3 and SPAWN_TICKS=1 over 200 ticks -> popcount(mole_up) never exceeds 3; no spawn ever lands on an index >= 12; reset asserted mid-game -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game scheduler.
package mole_pkg;

  localparam int unsigned N_HOLES = 12;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TIMER_W = 6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StPaused = 3'd2,
    StWin    = 3'd3,
    StLose   = 3'd4
  } state_e;

  function automatic logic [IDX_W-1:0] popcount(input logic [N_HOLES-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      c = c + IDX_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11), shifting right every clock.
module mole_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  localparam logic [15:0] TAPS = 16'hB400;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & TAPS);
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Game controller: spawns moles, ages them, resolves hammer hits and tracks lives/score.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int unsigned NUM_MOLES   = N_HOLES,
  parameter int unsigned UP_TICKS    = 48,
  parameter int unsigned SPAWN_TICKS = 16,
  parameter int unsigned MAX_ACTIVE  = 3,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned WIN_SCORE   = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 is_start,
  input  logic                 is_pause,
  input  logic                 hit_valid,
  input  logic [IDX_W-1:0]     hit_index,
  output logic [NUM_MOLES-1:0] mole_up,
  output logic [2:0]           live,
  output logic [7:0]           score,
  output logic                 is_win,
  output logic                 is_lose
);

  localparam logic [TIMER_W-1:0] UP_LOAD    = TIMER_W'(UP_TICKS);
  localparam logic [7:0]         SPAWN_LOAD = 8'(SPAWN_TICKS);
  localparam logic [2:0]         LIVES_LOAD = 3'(LIVES);
  localparam logic [7:0]         WIN_AT     = 8'(WIN_SCORE);
  localparam logic [IDX_W-1:0]   MAX_UP     = IDX_W'(MAX_ACTIVE);
  localparam logic [IDX_W-1:0]   HOLES      = IDX_W'(NUM_MOLES);

  state_e                 state_q, state_d;
  logic [NUM_MOLES-1:0]   mole_q, mole_d;
  logic [TIMER_W-1:0]     timer_q [NUM_MOLES];
  logic [TIMER_W-1:0]     timer_d [NUM_MOLES];
  logic [7:0]             spawn_q, spawn_d;
  logic [2:0]             live_q, live_d;
  logic [7:0]             score_q, score_d;
  logic                   win_q, win_d;
  logic                   lose_q, lose_d;

  logic [15:0]            lfsr_state;
  logic [IDX_W-1:0]       spawn_idx;
  logic                   unused_lfsr;

  logic [NUM_MOLES-1:0]   up;
  logic                   hit_ok;
  logic [IDX_W-1:0]       n_timeout;
  logic [7:0]             spawn_left;

  mole_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .lfsr (lfsr_state)
  );

  assign spawn_idx   = lfsr_state[IDX_W-1:0];
  assign unused_lfsr = ^lfsr_state[15:IDX_W];

  always_comb begin
    state_d    = state_q;
    mole_d     = mole_q;
    timer_d    = timer_q;
    spawn_d    = spawn_q;
    live_d     = live_q;
    score_d    = score_q;
    win_d      = win_q;
    lose_d     = lose_q;
    up         = mole_q;
    hit_ok     = 1'b0;
    n_timeout  = '0;
    spawn_left = '0;

    if (!is_start) begin
      state_d = StIdle;
      mole_d  = '0;
      timer_d = '{default: '0};
      spawn_d = '0;
      live_d  = LIVES_LOAD;
      score_d = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StRun;
          mole_d  = '0;
          timer_d = '{default: '0};
          spawn_d = SPAWN_LOAD;
          live_d  = LIVES_LOAD;
          score_d = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end
        StRun: begin
          // Hit is judged against the pre-cycle vector; ageing and spawn see the post-hit one.
          if (hit_valid && (hit_index < HOLES)) begin
            if (mole_q[hit_index]) begin
              hit_ok            = 1'b1;
              up[hit_index]     = 1'b0;
              timer_d[hit_index] = '0;
            end
          end

          if (tick) begin
            for (int i = 0; i < NUM_MOLES; i++) begin
              if (up[i]) begin
                if (timer_q[i] == TIMER_W'(1)) begin
                  up[i]      = 1'b0;
                  timer_d[i] = '0;
                  n_timeout  = n_timeout + IDX_W'(1);
                end else begin
                  timer_d[i] = timer_q[i] - TIMER_W'(1);
                end
              end
            end

            spawn_left = (spawn_q == 8'd0) ? 8'd0 : spawn_q - 8'd1;
            spawn_d    = spawn_left;
            // A failed attempt leaves the counter at zero so the next tick retries.
            if ((spawn_left == 8'd0) && (spawn_idx < HOLES)) begin
              if (!up[spawn_idx] && (popcount(up) < MAX_UP)) begin
                up[spawn_idx]      = 1'b1;
                timer_d[spawn_idx] = UP_LOAD;
                spawn_d            = SPAWN_LOAD;
              end
            end
          end

          mole_d = up;

          if (hit_ok && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end

          if ({1'b0, live_q} <= n_timeout) begin
            live_d = '0;
          end else begin
            live_d = live_q - n_timeout[2:0];
          end

          if (hit_ok && (score_d == WIN_AT)) begin
            state_d = StWin;
            win_d   = 1'b1;
            mole_d  = '0;
            timer_d = '{default: '0};
          end else if (live_d == 3'd0) begin
            state_d = StLose;
            lose_d  = 1'b1;
            mole_d  = '0;
            timer_d = '{default: '0};
          end else if (is_pause) begin
            state_d = StPaused;
          end
        end
        StPaused: begin
          if (!is_pause) begin
            state_d = StRun;
          end
        end
        StWin, StLose: begin
          state_d = state_q;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mole_q  <= '0;
      timer_q <= '{default: '0};
      spawn_q <= '0;
      live_q  <= LIVES_LOAD;
      score_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mole_q  <= mole_d;
      timer_q <= timer_d;
      spawn_q <= spawn_d;
      live_q  <= live_d;
      score_q <= score_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign mole_up = mole_q;
  assign live    = live_q;
  assign score   = score_q;
  assign is_win  = win_q;
  assign is_lose = lose_q;

endmodule
